// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: the op encodings the core
// drives on `op`, the controller state encoding, and a constant-evaluable
// ceil(log2) used to size the iteration counter.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Core <-> multiply/divide unit bundle.
//   start/op/in_a/in_b/flush : request side, driven by the core (master)
//   busy/done/hi/lo          : status and HI/LO registers, driven by the unit (slave)
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, in_a, in_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, in_a, in_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One combinational iteration step shared by multiply and divide.
//   is_div  : 0 = shift-add multiply step, 1 = restoring-division step
//   operand : multiplicand (mul) or divisor (div), magnitude form
//   hi_in/lo_in   : upper/lower accumulator halves before the step
//   hi_out/lo_out : accumulator halves after the step
// Multiply: lo holds the remaining multiplier bits (LSB consumed each step),
// hi the partial product; the pair shifts right by one.
// Divide: hi holds the partial remainder, lo the dividend bits (MSB consumed
// each step) and collects quotient bits from the right.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
        shifted = {hi_in, lo_in[WIDTH-1]};
        trial   = shifted - {1'b0, operand};
        fits    = (shifted >= {1'b0, operand});
        if (is_div) begin
            // Remainder stays below the divisor, so WIDTH bits always suffice.
            hi_out = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], fits};
        end else begin
            hi_out = sum[WIDTH:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk   : core clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : slave side of mul_div_unit_if (start/op/in_a/in_b/flush in,
//           busy/done/hi/lo out)
// Operands are reduced to magnitudes on entry, BITS_PER_CYCLE mdu_step
// instances iterate N = WIDTH/BITS_PER_CYCLE times, and a single FIXUP cycle
// applies the recorded signs before committing to HI/LO.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mul_div_unit_if.slave        bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (clog2(N) > 0) ? clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;   // negate product / quotient
    logic             neg_rem_q, neg_rem_d;   // negate remainder (sign of a)
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Step chain: element 0 is the registered accumulator, element
    // BITS_PER_CYCLE is the value after this cycle's iterations.
    logic [WIDTH-1:0] chain_hi [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] chain_lo [BITS_PER_CYCLE+1];

    assign chain_hi[0] = acc_hi_q;
    assign chain_lo[0] = acc_lo_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        mdu_step #(.WIDTH(WIDTH)) u_step (
            .is_div  (is_div_q),
            .operand (operand_q),
            .hi_in   (chain_hi[i]),
            .lo_in   (chain_lo[i]),
            .hi_out  (chain_hi[i+1]),
            .lo_out  (chain_lo[i+1])
        );
    end

    logic             signed_op;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through the
        // case statement leaves a signal unassigned (which would infer a latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        operand_d = operand_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        sign_a    = signed_op && bus.in_a[WIDTH-1];
        sign_b    = signed_op && bus.in_b[WIDTH-1];
        a_mag     = sign_a ? -bus.in_a : bus.in_a;
        b_mag     = sign_b ? -bus.in_b : bus.in_b;

        product  = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quot_fix = neg_res_q ? -acc_lo_q : acc_lo_q;
        // With a zero divisor the remainder ends up as |a|; re-applying the
        // sign of a reproduces in_a exactly, which is the required HI value.
        rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

        case (state_q)
            S_IDLE: begin
                // flush in the same cycle drops the request, MTHI/MTLO included.
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                            neg_res_d = sign_a ^ sign_b;
                            neg_rem_d = sign_a;
                            b_zero_d  = (bus.in_b == '0);
                            cnt_d     = '0;
                            acc_hi_d  = '0;
                            acc_lo_d  = is_div_d ? a_mag : b_mag;
                            operand_d = is_div_d ? b_mag : a_mag;
                            state_d   = S_CALC;
                        end
                        OP_MTHI: hi_d = bus.in_a;
                        OP_MTLO: lo_d = bus.in_a;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_hi_d = chain_hi[BITS_PER_CYCLE];
                    acc_lo_d = chain_lo[BITS_PER_CYCLE];
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = product;
                    end else if (b_zero_q) begin
                        lo_d = '1;
                        hi_d = rem_fix;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: all state is cleared by the asynchronous reset; none of these
    // flops is a storage array, so there is no reason to leave any unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            operand_q <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge
            // values computed above, independent of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            operand_q <= operand_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the pipelined MIPS core, with architectural HI/LO registers.
- Adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support.
- Sits beside the ALU in EX. The core's hazard unit stalls MFHI/MFLO while `busy` is high.
- Width and iteration throughput are parametrised so the same unit serves 32-bit and reduced-width builds and trades area against latency.

Parameters:
- WIDTH, 32: operand, HI and LO width; must be even and ≥ 4.
- BITS_PER_CYCLE, 1: product/quotient bits resolved per cycle; must divide WIDTH (1, 2, 4).
- Derived N = WIDTH/BITS_PER_CYCLE: number of iteration cycles.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are no-op.
- in_a  in  WIDTH  rs operand (already forwarded).
- in_b  in  WIDTH  rt operand (already forwarded).
- flush  in  1  abort the in-flight operation (exception/interrupt).
- busy  out  1  operation in progress (CALC or FIXUP).
- done  out  1  one-cycle pulse when HI/LO are updated by a mul/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - hi, lo, busy, done and all internal accumulators/counters are 0.
- States: IDLE, CALC, FIXUP.
- IDLE:
  - start=1 with op 0–3: latch operands and go to CALC with the counter at 0.
    - Signed ops (MULT, DIV) latch |in_a| and |in_b|, recording the result signs: product sign = sign_a^sign_b; quotient sign = sign_a^sign_b; remainder sign = sign_a.
    - Unsigned ops latch the operands unchanged.
  - start=1 with op 4 (MTHI) or op 5 (MTLO): write in_a into hi or lo at that edge. No state change, no done.
  - start=1 with op 6–7: ignored.
  - start=0: remain in IDLE.
- CALC, each cycle:
  - Multiply: BITS_PER_CYCLE shift-add steps on a 2·WIDTH accumulator.
  - Divide: BITS_PER_CYCLE restoring-division steps.
  - Increment the counter. When counter = N−1, go to FIXUP.
- FIXUP, one cycle:
  - Negate results per the recorded signs.
  - Multiply: {hi,lo} = 2·WIDTH product.
  - Divide: lo = quotient, hi = remainder.
  - Go to IDLE; done=1 for exactly the following cycle.
- Latency:
  - start is accepted at edge 0.
  - busy=1 from after edge 0 through edge N+1.
  - hi/lo are updated and done rises at edge N+1.
  - Total is N+1 cycles (33 for the defaults).
  - MTHI/MTLO take effect at edge 0.
- Divide by zero (in_b=0, any div op): result lo = all-ones, hi = in_a as supplied (unsigned bit pattern); same N+1-cycle latency.
- Signed overflow (DIV of the most-negative value by −1): lo = most-negative value, hi = 0. No trap.
- start while busy: ignored, including MTHI/MTLO. The core must not issue these; a bench checker flags it.
- flush while busy (CALC or FIXUP): at the next edge go to IDLE and clear busy. hi/lo keep their pre-operation values; no done pulse.
- flush and start in the same IDLE cycle: flush wins and start is dropped.
- done:
  - Deasserts the cycle after it is asserted.
  - A new start in the IDLE cycle where done=1 is accepted normally.
- Reset asserted mid-operation aborts immediately; all outputs go to their reset values.
- hi and lo are registers that only change at the events listed above.

Decomposition:
- Shared package `mdu_pkg`:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO);
  - state encoding (S_IDLE, S_CALC, S_FIXUP);
  - counter width function clog2(N).
- One natural sub-module, `mdu_step`: a combinational single-bit step (shift-add or restore-subtract selected by a mode input). It is instantiated BITS_PER_CYCLE times in a chain inside mul_div_unit.

Test Plan (all with WIDTH=32, BITS_PER_CYCLE=1):
1. MULT, in_a=0xFFFFFFFE (−2), in_b=0x00000003 → at edge 33: hi=0xFFFFFFFF, lo=0xFFFFFFFA; done high one cycle; busy high cycles 1–33.
2. DIVU, in_a=100, in_b=7 → lo=14, hi=2. Then DIV, in_a=−7, in_b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
3. DIV, in_a=0x12345678, in_b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV, in_a=0x80000000, in_b=0xFFFFFFFF → lo=0x80000000, hi=0.
4. Preload hi=0xAAAA0000 via MTHI, start MULTU (5×5), assert flush at cycle 10 → busy=0 at cycle 11, hi=0xAAAA0000 unchanged, lo unchanged, no done.
5. Start while busy with MTLO in_a=0x55 → lo unaffected; final lo equals the mul result. Back-to-back start in the done cycle is accepted; done pulses again 33 cycles later.
6. Reset pulled low at cycle 15 of a DIVU → hi=lo=0, busy=0, done=0 asynchronously. Repeat tests 1–2 with BITS_PER_CYCLE=4 → identical results at edge 9.
